// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared types and encodings for the RVC fetch aligner and its expander.
// Holds opcode constants, the C2 "other" selector and the canonical illegal halfword.
package rvc_fetch_aligner_pkg;

   localparam logic [15:0] RVC_ILLEGAL = 16'h0000;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      C2_JR,
      C2_MV,
      C2_EBREAK,
      C2_JALR,
      C2_ADD
   } c2_other_t;

   // C2 funct3=100 is split on bit12 and whether rs2 (and then rd) is x0
   function automatic c2_other_t c2_other_sel(input logic bit12,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs2);
      if (!bit12)
         return (rs2 == 5'd0) ? C2_JR : C2_MV;
      if (rs2 != 5'd0)
         return C2_ADD;
      return (rd == 5'd0) ? C2_EBREAK : C2_JALR;
   endfunction

   function automatic logic [4:0] rvc_reg(input logic [2:0] r);
      return {2'b01, r};
   endfunction

endpackage

// File: rtl/rvc_fetch_aligner_expander.sv
// Combinational RVC -> RV32I expander.
// Reserved or unsupported encodings raise illegal and return the raw halfword zero-extended.
module rvc_expander
   import rvc_fetch_aligner_pkg::*;
(
   input  logic [15:0] hw,
   output logic [31:0] inst,
   output logic        illegal
);

   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs1p;
   logic [9:0]  addi4spn_imm;
   logic [6:0]  lw_off;
   logic [11:0] cj_off;
   logic [8:0]  cb_off;
   logic [9:0]  addi16sp_imm;
   logic [7:0]  lwsp_off;
   logic [7:0]  swsp_off;
   logic [31:0] exp_inst;
   logic        ill;
   c2_other_t   c2_sel;

   assign rd   = hw[11:7];
   assign rs2  = hw[6:2];
   assign rdp  = rvc_reg(hw[4:2]);
   assign rs1p = rvc_reg(hw[9:7]);

   // Immediate scatter patterns of the compressed formats
   assign addi4spn_imm = {hw[10:7], hw[12:11], hw[5], hw[6], 2'b00};
   assign lw_off       = {hw[5], hw[12:10], hw[6], 2'b00};
   assign cj_off       = {hw[12], hw[8], hw[10:9], hw[6], hw[7], hw[2], hw[11], hw[5:3], 1'b0};
   assign cb_off       = {hw[12], hw[6:5], hw[2], hw[11:10], hw[4:3], 1'b0};
   assign addi16sp_imm = {hw[12], hw[4:3], hw[5], hw[2], hw[6], 4'b0000};
   assign lwsp_off     = {hw[3:2], hw[12], hw[6:4], 2'b00};
   assign swsp_off     = {hw[8:7], hw[12:9], 2'b00};
   assign c2_sel       = c2_other_sel(hw[12], rd, rs2);

   always_comb begin
      exp_inst = '0;
      ill      = 1'b0;
      case (hw[1:0])
         2'b00: begin
            case (hw[15:13])
               3'b000: begin
                  ill      = (addi4spn_imm == '0);
                  exp_inst = {2'b00, addi4spn_imm, 5'd2, 3'b000, rdp, OPC_OP_IMM};
               end
               3'b010: exp_inst = {5'b0, lw_off, rs1p, 3'b010, rdp, OPC_LOAD};
               3'b110: exp_inst = {5'b0, lw_off[6:5], rdp, rs1p, 3'b010, lw_off[4:0], OPC_STORE};
               default: ill = 1'b1;
            endcase
         end
         2'b01: begin
            case (hw[15:13])
               3'b000: exp_inst = {{7{hw[12]}}, hw[6:2], rd, 3'b000, rd, OPC_OP_IMM};
               3'b001: exp_inst = {cj_off[11], cj_off[10:1], cj_off[11], {8{cj_off[11]}}, 5'd1, OPC_JAL};
               3'b010: exp_inst = {{7{hw[12]}}, hw[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
               3'b011: begin
                  if (rd == 5'd2) begin
                     ill      = (addi16sp_imm == '0);
                     exp_inst = {{2{addi16sp_imm[9]}}, addi16sp_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                  end else begin
                     ill      = ({hw[12], hw[6:2]} == 6'd0);
                     exp_inst = {{15{hw[12]}}, hw[6:2], rd, OPC_LUI};
                  end
               end
               3'b100: begin
                  case (hw[11:10])
                     2'b00: begin
                        ill      = hw[12];
                        exp_inst = {7'b0000000, hw[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                     end
                     2'b01: begin
                        ill      = hw[12];
                        exp_inst = {7'b0100000, hw[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                     end
                     2'b10: exp_inst = {{7{hw[12]}}, hw[6:2], rs1p, 3'b111, rs1p, OPC_OP_IMM};
                     default: begin
                        // bit12=1 selects the RV64 word ops, which do not exist here
                        ill = hw[12];
                        case (hw[6:5])
                           2'b00:   exp_inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                           2'b01:   exp_inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                           2'b10:   exp_inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                           default: exp_inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                        endcase
                     end
                  endcase
               end
               3'b101: exp_inst = {cj_off[11], cj_off[10:1], cj_off[11], {8{cj_off[11]}}, 5'd0, OPC_JAL};
               3'b110: exp_inst = {{4{cb_off[8]}}, cb_off[7:5], 5'd0, rs1p, 3'b000,
                                   cb_off[4:1], cb_off[8], OPC_BRANCH};
               default: exp_inst = {{4{cb_off[8]}}, cb_off[7:5], 5'd0, rs1p, 3'b001,
                                    cb_off[4:1], cb_off[8], OPC_BRANCH};
            endcase
         end
         2'b10: begin
            case (hw[15:13])
               3'b000: begin
                  ill      = hw[12];
                  exp_inst = {7'b0000000, hw[6:2], rd, 3'b001, rd, OPC_OP_IMM};
               end
               3'b010: begin
                  ill      = (rd == 5'd0);
                  exp_inst = {4'b0000, lwsp_off, 5'd2, 3'b010, rd, OPC_LOAD};
               end
               3'b100: begin
                  case (c2_sel)
                     C2_JR: begin
                        ill      = (rd == 5'd0);
                        exp_inst = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
                     end
                     C2_MV:     exp_inst = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
                     C2_EBREAK: exp_inst = {12'h001, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
                     C2_JALR:   exp_inst = {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
                     default:   exp_inst = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
                  endcase
               end
               3'b110: exp_inst = {4'b0000, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OPC_STORE};
               default: ill = 1'b1;
            endcase
         end
         default: exp_inst = {16'h0000, hw};
      endcase
      if (hw == RVC_ILLEGAL)
         ill = 1'b1;
   end

   assign illegal = ill;
   assign inst    = ill ? {16'h0000, hw} : exp_inst;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Realigns the word-aligned fetch stream into halfword-granular instructions,
// expanding RVC encodings so decode only ever sees 32-bit instructions.
module rvc_fetch_aligner
   import rvc_fetch_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h1eceb000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_compressed,
   output logic        inst_illegal
);

   logic [15:0] hb_q [3];
   logic [15:0] hb_d [3];
   logic [1:0]  cnt_q;
   logic [1:0]  cnt_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        skip_lo_q;
   logic        skip_lo_d;

   logic        head_c;
   logic [31:0] exp_inst;
   logic        exp_illegal;
   logic [1:0]  pop_n;
   logic [1:0]  push_n;
   logic [1:0]  rem;
   logic [15:0] push_hw [2];

   rvc_expander u_expander (
      .hw      (hb_q[0]),
      .inst    (exp_inst),
      .illegal (exp_illegal)
   );

   assign head_c          = (hb_q[0][1:0] != 2'b11);
   assign inst_valid      = !flush && ((cnt_q != 2'd0 && head_c) || cnt_q >= 2'd2);
   assign fetch_ready     = !flush && (cnt_q <= 2'd1);
   assign inst            = head_c ? exp_inst : {hb_q[1], hb_q[0]};
   assign inst_pc         = pc_q;
   assign inst_compressed = head_c;
   assign inst_illegal    = head_c && exp_illegal;

   always_comb begin
      pop_n      = '0;
      push_n     = '0;
      push_hw[0] = fetch_data[15:0];
      push_hw[1] = fetch_data[31:16];
      skip_lo_d  = skip_lo_q;

      if (inst_valid && inst_ready)
         pop_n = head_c ? 2'd1 : 2'd2;

      if (fetch_valid && fetch_ready) begin
         skip_lo_d = 1'b0;
         if (skip_lo_q) begin
            push_n     = 2'd1;
            push_hw[0] = fetch_data[31:16];
         end else begin
            push_n = 2'd2;
         end
      end

      // Survivors shift down by the pop count; new halfwords fill in directly behind them
      rem = cnt_q - pop_n;
      for (int unsigned i = 0; i < 3; i++) begin
         logic [2:0] src;
         logic [2:0] slot;
         src  = 3'(i) + {1'b0, pop_n};
         slot = 3'(i) - {1'b0, rem};
         if (3'(i) < {1'b0, rem})
            hb_d[i] = hb_q[src[1:0]];
         else if (slot == 3'd0)
            hb_d[i] = push_hw[0];
         else
            hb_d[i] = push_hw[1];
      end

      cnt_d = rem + push_n;
      pc_d  = pc_q + {29'b0, pop_n, 1'b0};

      if (flush) begin
         cnt_d     = '0;
         pc_d      = flush_pc;
         skip_lo_d = flush_pc[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++)
            hb_q[i] <= '0;
         cnt_q     <= '0;
         pc_q      <= RESET_VECTOR;
         skip_lo_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 3; i++)
            hb_q[i] <= hb_d[i];
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         skip_lo_q <= skip_lo_d;
      end
   end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Self-checking bench for rvc_fetch_aligner: directed scenarios plus randomized traffic
// checked against a halfword-queue reference model with its own RVC decoder.
module tb_rvc_fetch_aligner;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_data;
   logic        flush;
   logic [31:0] flush_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_compressed;
   logic        inst_illegal;

   int checks   = 0;
   int failures = 0;

   rvc_fetch_aligner #(.RESET_VECTOR(32'h1eceb000)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_data      (fetch_data),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_compressed (inst_compressed),
      .inst_illegal    (inst_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference encoders / RVC decoder ----------------
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, int op);
      logic [31:0] v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'(op)};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3, int op);
      logic [31:0] v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'(op)};
   endfunction
   function automatic logic [31:0] enc_u(int imm20, int rd, int op);
      logic [31:0] v = imm20;
      return {v[19:0], 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_j(int imm, int rd, int op);
      logic [31:0] v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'(op)};
   endfunction

   function automatic void ref_expand(input logic [15:0] c, output logic [31:0] x, output logic ill);
      int rd   = c[11:7];
      int rs2  = c[6:2];
      int rdp  = 8 + c[4:2];
      int rs1p = 8 + c[9:7];
      int i6   = c[6:2] - (c[12] ? 32 : 0);
      int u6   = c[6:2];
      int imm;
      ill = 1'b0;
      x   = 32'h0;
      case (c[1:0])
         2'd0: case (c[15:13])
            3'd0: begin
               imm = c[10:7] * 64 + c[12:11] * 16 + c[5] * 8 + c[6] * 4;
               if (imm == 0) ill = 1'b1; else x = enc_i(imm, 2, 0, rdp, 'h13);
            end
            3'd2: x = enc_i(c[5] * 64 + c[12:10] * 8 + c[6] * 4, rs1p, 2, rdp, 'h03);
            3'd6: x = enc_s(c[5] * 64 + c[12:10] * 8 + c[6] * 4, rdp, rs1p, 2, 'h23);
            default: ill = 1'b1;
         endcase
         2'd1: case (c[15:13])
            3'd0: x = enc_i(i6, rd, 0, rd, 'h13);
            3'd1, 3'd5: begin
               imm = (c[12] ? -2048 : 0) + c[8] * 1024 + c[10:9] * 256 + c[6] * 128 + c[7] * 64
                     + c[2] * 32 + c[11] * 16 + c[5:3] * 2;
               x = enc_j(imm, (c[15:13] == 3'd1) ? 1 : 0, 'h6f);
            end
            3'd2: x = enc_i(i6, 0, 0, rd, 'h13);
            3'd3: begin
               if (rd == 2) begin
                  imm = (c[12] ? -512 : 0) + c[4:3] * 128 + c[5] * 64 + c[2] * 32 + c[6] * 16;
                  if (imm == 0) ill = 1'b1; else x = enc_i(imm, 2, 0, 2, 'h13);
               end else begin
                  if (i6 == 0) ill = 1'b1; else x = enc_u(i6, rd, 'h37);
               end
            end
            3'd4: case (c[11:10])
               2'd0: if (c[12]) ill = 1'b1; else x = enc_i(u6, rs1p, 5, rs1p, 'h13);
               2'd1: if (c[12]) ill = 1'b1; else x = enc_i('h400 + u6, rs1p, 5, rs1p, 'h13);
               2'd2: x = enc_i(i6, rs1p, 7, rs1p, 'h13);
               default: begin
                  if (c[12]) ill = 1'b1;
                  else case (c[6:5])
                     2'd0: x = enc_r('h20, rdp, rs1p, 0, rs1p, 'h33);
                     2'd1: x = enc_r(0, rdp, rs1p, 4, rs1p, 'h33);
                     2'd2: x = enc_r(0, rdp, rs1p, 6, rs1p, 'h33);
                     default: x = enc_r(0, rdp, rs1p, 7, rs1p, 'h33);
                  endcase
               end
            endcase
            default: begin
               imm = (c[12] ? -256 : 0) + c[6:5] * 64 + c[2] * 32 + c[11:10] * 8 + c[4:3] * 2;
               x = enc_b(imm, 0, rs1p, (c[15:13] == 3'd6) ? 0 : 1, 'h63);
            end
         endcase
         2'd2: case (c[15:13])
            3'd0: if (c[12]) ill = 1'b1; else x = enc_i(u6, rd, 1, rd, 'h13);
            3'd2: if (rd == 0) ill = 1'b1;
                  else x = enc_i(c[3:2] * 64 + c[12] * 32 + c[6:4] * 4, 2, 2, rd, 'h03);
            3'd4: begin
               if (!c[12]) begin
                  if (rs2 != 0) x = enc_r(0, rs2, 0, 0, rd, 'h33);
                  else if (rd == 0) ill = 1'b1;
                  else x = enc_i(0, rd, 0, 0, 'h67);
               end else begin
                  if (rs2 != 0) x = enc_r(0, rs2, rd, 0, rd, 'h33);
                  else if (rd == 0) x = 32'h00100073;
                  else x = enc_i(0, rd, 0, 1, 'h67);
               end
            end
            3'd6: x = enc_s(c[8:7] * 64 + c[12:9] * 4, rs2, 2, 2, 'h23);
            default: ill = 1'b1;
         endcase
         default: ill = 1'b0;
      endcase
      if (ill) x = {16'h0000, c};
   endfunction

   function automatic logic [15:0] gen_hw();
      int unsigned r = $urandom_range(0, 7);
      logic [15:0] h = 16'($urandom);
      if (r == 0) return 16'h0000;
      if (r <= 5) h[1:0] = 2'($urandom_range(0, 2));
      return h;
   endfunction

   task automatic apply_reset();
      rst = 1'b1; fetch_valid = 1'b0; inst_ready = 1'b0; flush = 1'b0;
      flush_pc = 32'h0; fetch_data = 32'h0;
      #2;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; fetch_valid = 1'b0; inst_ready = 1'b1; flush = 1'b0;
      flush_pc = 32'h0; fetch_data = 32'h0;
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_in_valid got=%b exp=0", inst_valid); end
      rst = 1'b0; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL reset_fready got=%b exp=1", fetch_ready); end
      @(negedge clk);
   endtask

   task automatic test_aligned_word();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h00000013; #1;
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL aligned_fready got=%b exp=1", fetch_ready); end
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1; #1;
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL aligned_valid got=%b exp=1", inst_valid); end
      checks++; if (inst !== 32'h00000013) begin failures++; $display("FAIL aligned_inst got=%h exp=00000013", inst); end
      checks++; if (inst_pc !== 32'h1eceb000) begin failures++; $display("FAIL aligned_pc got=%h exp=1eceb000", inst_pc); end
      checks++; if (inst_compressed !== 1'b0) begin failures++; $display("FAIL aligned_c got=%b exp=0", inst_compressed); end
      @(negedge clk); fetch_valid = 1'b1; inst_ready = 1'b0; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL aligned_empty got=%b exp=0", inst_valid); end
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1; #1;
      checks++; if (inst_pc !== 32'h1eceb004) begin failures++; $display("FAIL aligned_pc2 got=%h exp=1eceb004", inst_pc); end
      @(negedge clk); inst_ready = 1'b0;
   endtask

   task automatic test_compressed_pair();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h45014485;
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1; #1;
      checks++; if (inst !== 32'h00100493 || inst_pc !== 32'h1eceb000)
         begin failures++; $display("FAIL cpair_first got=%h@%h exp=00100493@1eceb000", inst, inst_pc); end
      checks++; if (inst_compressed !== 1'b1) begin failures++; $display("FAIL cpair_c got=%b exp=1", inst_compressed); end
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000513 || inst_pc !== 32'h1eceb002)
         begin failures++; $display("FAIL cpair_second got=%b %h@%h exp=1 00000513@1eceb002", inst_valid, inst, inst_pc); end
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL cpair_drained got=%b exp=0", inst_valid); end
      inst_ready = 1'b0;
   endtask

   task automatic test_straddle();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h05934485;
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1; #1;
      checks++; if (inst !== 32'h00100493 || inst_pc !== 32'h1eceb000)
         begin failures++; $display("FAIL strad_first got=%h@%h exp=00100493@1eceb000", inst, inst_pc); end
      checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL strad_full got=%b exp=0", fetch_ready); end
      @(negedge clk); fetch_valid = 1'b1; fetch_data = 32'h45010050; #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL strad_wait got=%b exp=0", inst_valid); end
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL strad_fready got=%b exp=1", fetch_ready); end
      @(negedge clk); fetch_valid = 1'b0; #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00500593 || inst_pc !== 32'h1eceb002 || inst_compressed !== 1'b0)
         begin failures++; $display("FAIL strad_join got=%b %h@%h c=%b exp=1 00500593@1eceb002 c=0", inst_valid, inst, inst_pc, inst_compressed); end
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000513 || inst_pc !== 32'h1eceb006)
         begin failures++; $display("FAIL strad_tail got=%b %h@%h exp=1 00000513@1eceb006", inst_valid, inst, inst_pc); end
      @(negedge clk); inst_ready = 1'b0;
   endtask

   task automatic test_flush_skip();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h00000013;
      @(negedge clk); flush = 1'b1; flush_pc = 32'h1eceb102; inst_ready = 1'b1; #1;
      checks++; if (inst_valid !== 1'b0 || fetch_ready !== 1'b0)
         begin failures++; $display("FAIL flush_block got=%b/%b exp=0/0", inst_valid, fetch_ready); end
      @(negedge clk); flush = 1'b0; fetch_data = 32'h4501FFFF; #1;
      checks++; if (inst_valid !== 1'b0 || fetch_ready !== 1'b1)
         begin failures++; $display("FAIL flush_empty got=%b/%b exp=0/1", inst_valid, fetch_ready); end
      @(negedge clk); fetch_valid = 1'b0; #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000513 || inst_pc !== 32'h1eceb102)
         begin failures++; $display("FAIL flush_target got=%b %h@%h exp=1 00000513@1eceb102", inst_valid, inst, inst_pc); end
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL flush_skiplo got=%b exp=0", inst_valid); end
      inst_ready = 1'b0;
   endtask

   task automatic test_illegal_zero();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h45010000;
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1; #1;
      checks++; if (inst_valid !== 1'b1 || inst_illegal !== 1'b1 || inst !== 32'h00000000)
         begin failures++; $display("FAIL illeg_zero got=%b ill=%b %h exp=1 ill=1 00000000", inst_valid, inst_illegal, inst); end
      @(negedge clk); #1;
      checks++; if (inst_illegal !== 1'b0 || inst !== 32'h00000513 || inst_pc !== 32'h1eceb002)
         begin failures++; $display("FAIL illeg_next got=ill=%b %h@%h exp=ill=0 00000513@1eceb002", inst_illegal, inst, inst_pc); end
      @(negedge clk); inst_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h45014485;
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clk); fetch_valid = 1'b1; fetch_data = 32'h00000013; inst_ready = 1'b0; #1;
      checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", fetch_ready); end
      @(negedge clk); fetch_data = 32'hdeadbeef;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (fetch_ready !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h00000513 || inst_pc !== 32'h1eceb002)
            begin failures++; $display("FAIL bp_hold[%0d] got=%b %b %h@%h exp=0 1 00000513@1eceb002", k, fetch_ready, inst_valid, inst, inst_pc); end
         @(negedge clk);
      end
      fetch_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_pc !== 32'h1eceb004)
         begin failures++; $display("FAIL bp_release got=%b %h@%h exp=1 00000013@1eceb004", inst_valid, inst, inst_pc); end
      @(negedge clk); inst_ready = 1'b0;
   endtask

   task automatic test_reset_mid_straddle();
      apply_reset();
      fetch_valid = 1'b1; fetch_data = 32'h05934485;
      @(negedge clk); fetch_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clk); #1;
      rst = 1'b1; #1;
      checks++; if (inst_valid !== 1'b0 || fetch_ready !== 1'b1)
         begin failures++; $display("FAIL rststrad_state got=%b/%b exp=0/1", inst_valid, fetch_ready); end
      @(negedge clk); rst = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h00000013;
      @(negedge clk); fetch_valid = 1'b0; #1;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_pc !== 32'h1eceb000 || inst_compressed !== 1'b0)
         begin failures++; $display("FAIL rststrad_restart got=%b %h@%h c=%b exp=1 00000013@1eceb000 c=0", inst_valid, inst, inst_pc, inst_compressed); end
      @(negedge clk); inst_ready = 1'b0;
   endtask

   // ---------------- randomized traffic vs queue model ----------------
   task automatic test_random();
      logic [15:0] hq[$];
      logic [31:0] mpc = 32'h1eceb000;
      logic        mskip = 1'b0;
      logic [31:0] e_inst;
      logic        e_ill;
      logic        e_valid;
      logic        e_ready;
      logic        h_c;
      int          n;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         fetch_valid = ($urandom_range(0, 9) < 7);
         fetch_data  = {gen_hw(), gen_hw()};
         inst_ready  = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 39) == 0);
         flush_pc    = {$urandom, 1'b0} & 32'hffff_fffe;
         #1;
         h_c     = (hq.size() > 0) && (hq[0][1:0] != 2'b11);
         e_valid = !flush && ((hq.size() >= 1 && h_c) || hq.size() >= 2);
         e_ready = !flush && (hq.size() <= 1);
         checks++; if (fetch_ready !== e_ready) begin failures++;
            if (failures <= 20) $display("FAIL rnd_fready cyc=%0d got=%b exp=%b", cyc, fetch_ready, e_ready); end
         checks++; if (inst_valid !== e_valid) begin failures++;
            if (failures <= 20) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, e_valid); end
         if (e_valid) begin
            if (h_c) ref_expand(hq[0], e_inst, e_ill);
            else begin e_inst = {hq[1], hq[0]}; e_ill = 1'b0; end
            checks++; if (inst !== e_inst || inst_pc !== mpc || inst_compressed !== h_c || inst_illegal !== e_ill) begin
               failures++;
               if (failures <= 20) $display("FAIL rnd_inst cyc=%0d got=%h@%h c=%b i=%b exp=%h@%h c=%b i=%b",
                  cyc, inst, inst_pc, inst_compressed, inst_illegal, e_inst, mpc, h_c, e_ill);
            end
         end
         if (flush) begin
            hq.delete();
            mpc   = flush_pc;
            mskip = flush_pc[1];
         end else begin
            if (e_valid && inst_ready) begin
               n = h_c ? 1 : 2;
               for (int k = 0; k < n; k++) void'(hq.pop_front());
               mpc = mpc + 32'(2 * n);
            end
            if (fetch_valid && e_ready) begin
               if (!mskip) hq.push_back(fetch_data[15:0]);
               hq.push_back(fetch_data[31:16]);
               mskip = 1'b0;
            end
         end
         @(negedge clk);
      end
      fetch_valid = 1'b0; inst_ready = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_aligned_word();
      test_compressed_pair();
      test_straddle();
      test_flush_skip();
      test_illegal_zero();
      test_backpressure();
      test_reset_mid_straddle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
